// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command bytes for the LCD controller.
// LCD_CURSOR_PISCANTE_EN selects a blinking cursor in the display-on command.
package lcd_pkg;

    typedef enum logic [2:0] {
        ESPERA_LIGAR,
        INIT,
        OCIOSO,
        LIMPANDO,
        ESCREVENDO,
        FIM,
        DESLIGANDO,
        DESLIGADO
    } estado_t;

    typedef enum logic [1:0] {
        F_LIVRE,
        F_SETUP,
        F_ENABLE,
        F_ESPERA
    } fase_t;

    localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
    localparam logic [7:0] CMD_DISP_ON_CUR  = 8'h0F;
    localparam logic [7:0] CMD_DISP_OFF     = 8'h08;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_ENTRY        = 8'h06;
    localparam logic [7:0] CMD_LINHA1       = 8'h80;
    localparam logic [7:0] CMD_LINHA2       = 8'hC0;

`ifdef LCD_CURSOR_PISCANTE_EN
    localparam logic [7:0] CMD_LIGAR = CMD_DISP_ON_CUR;
`else
    localparam logic [7:0] CMD_LIGAR = CMD_DISP_ON;
`endif

    function automatic logic [7:0] cmd_init(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_8BIT_2L;
            2'd1:    return CMD_LIGAR;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    // Only the clear/home commands need the long settling time; data bytes never do.
    function automatic logic usa_espera_longa(input logic rs, input logic [7:0] dado);
        return !rs && (dado == CMD_CLEAR || dado == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_escritor_byte.sv
// Single-byte LCD bus writer: setup cycle, E strobe, then post-byte settling wait.
// Accepts `envia` only while `livre`; RS/DATA stay on the bus until the next byte.
module lcd_escritor_byte
    import lcd_pkg::*;
#(
    parameter int T_EN_CYC    = 50,
    parameter int T_CMD_CYC   = 2_500,
    parameter int T_CLEAR_CYC = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       envia,
    input  logic       rs,
    input  logic [7:0] dado,
    output logic       livre,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam int T_MAX_A = (T_CLEAR_CYC > T_CMD_CYC) ? T_CLEAR_CYC : T_CMD_CYC;
    localparam int T_MAX   = (T_MAX_A > T_EN_CYC) ? T_MAX_A : T_EN_CYC;
    localparam int CW      = $clog2(T_MAX + 1);

    fase_t          fase_reg, fase_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           rs_reg, rs_next;
    logic [7:0]     dado_reg, dado_next;
    logic           longo_reg, longo_next;
    logic [CW-1:0]  limite;

    assign limite = longo_reg ? CW'(T_CLEAR_CYC - 1) : CW'(T_CMD_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fase_reg  <= F_LIVRE;
            cnt_reg   <= '0;
            rs_reg    <= 1'b0;
            dado_reg  <= 8'h00;
            longo_reg <= 1'b0;
        end else begin
            fase_reg  <= fase_next;
            cnt_reg   <= cnt_next;
            rs_reg    <= rs_next;
            dado_reg  <= dado_next;
            longo_reg <= longo_next;
        end
    end

    always_comb begin
        fase_next  = fase_reg;
        cnt_next   = cnt_reg;
        rs_next    = rs_reg;
        dado_next  = dado_reg;
        longo_next = longo_reg;
        case (fase_reg)
            F_LIVRE: begin
                if (envia) begin
                    rs_next    = rs;
                    dado_next  = dado;
                    longo_next = usa_espera_longa(rs, dado);
                    fase_next  = F_SETUP;
                end
            end
            F_SETUP: begin
                cnt_next  = '0;
                fase_next = F_ENABLE;
            end
            F_ENABLE: begin
                if (cnt_reg == CW'(T_EN_CYC - 1)) begin
                    cnt_next  = '0;
                    fase_next = F_ESPERA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                if (cnt_reg == limite) begin
                    cnt_next  = '0;
                    fase_next = F_LIVRE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
        endcase
    end

    assign livre    = (fase_reg == F_LIVRE);
    assign lcd_e    = (fase_reg == F_ENABLE);
    assign lcd_rs   = rs_reg;
    assign lcd_data = dado_reg;

endmodule

// File: rtl/controlador_lcd.sv
// 16x2 HD44780 sequencer: power-up wait, init, then frame-write / clear requests.
// Define LCD_CURSOR_PISCANTE_EN for a blinking cursor in the display-on command.
module controlador_lcd
    import lcd_pkg::*;
#(
    parameter int T_POWERUP_CYC = 1_000_000,
    parameter int T_EN_CYC      = 50,
    parameter int T_CMD_CYC     = 2_500,
    parameter int T_CLEAR_CYC   = 100_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         habilitar,
    input  logic         inicio,
    input  logic         limpar,
    input  logic [127:0] linha1,
    input  logic [127:0] linha2,
    output logic         pronto,
    output logic         ocupado,
    output logic         concluido,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_data
);

    localparam int TW = $clog2(T_POWERUP_CYC + 1);

    estado_t        estado_reg, estado_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [4:0]     idx_reg, idx_next;
    logic           cab_reg, cab_next;
    logic           fim_reg, fim_next;
    logic [255:0]   linhas_reg, linhas_next;

    logic           envia, env_rs, livre;
    logic [7:0]     env_dado, caractere;
    logic [7:0]     chars [32];

    // Character i of the frame: row 1 is 0..15, row 2 is 16..31, leftmost first.
    for (genvar gi = 0; gi < 32; gi++) begin : g_char
        assign chars[gi] = linhas_reg[255 - 8*gi -: 8];
    end
    assign caractere = chars[idx_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg <= ESPERA_LIGAR;
            timer_reg  <= '0;
            idx_reg    <= 5'd0;
            cab_reg    <= 1'b0;
            fim_reg    <= 1'b0;
            linhas_reg <= '0;
        end else begin
            estado_reg <= estado_next;
            timer_reg  <= timer_next;
            idx_reg    <= idx_next;
            cab_reg    <= cab_next;
            fim_reg    <= fim_next;
            linhas_reg <= linhas_next;
        end
    end

    // fim_reg means every byte of the current state has been handed to the writer;
    // the state is left once the writer is free again.
    always_comb begin
        estado_next = estado_reg;
        timer_next  = timer_reg;
        idx_next    = idx_reg;
        cab_next    = cab_reg;
        fim_next    = fim_reg;
        linhas_next = linhas_reg;
        envia       = 1'b0;
        env_rs      = 1'b0;
        env_dado    = 8'h00;
        case (estado_reg)
            ESPERA_LIGAR: begin
                if (timer_reg == TW'(T_POWERUP_CYC - 1)) begin
                    estado_next = INIT;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            INIT: begin
                if (livre) begin
                    if (fim_reg) begin
                        estado_next = habilitar ? OCIOSO : DESLIGADO;
                    end else begin
                        envia    = 1'b1;
                        env_dado = cmd_init(idx_reg[1:0]);
                        if (idx_reg == 5'd3) fim_next = 1'b1;
                        else                 idx_next = idx_reg + 5'd1;
                    end
                end
            end
            OCIOSO: begin
                if (limpar) begin
                    estado_next = LIMPANDO;
                end else if (inicio) begin
                    linhas_next = {linha1, linha2};
                    estado_next = ESCREVENDO;
                end else if (!habilitar) begin
                    estado_next = DESLIGANDO;
                end
            end
            LIMPANDO: begin
                if (livre) begin
                    if (fim_reg) begin
                        estado_next = FIM;
                    end else begin
                        envia    = 1'b1;
                        env_dado = CMD_CLEAR;
                        fim_next = 1'b1;
                    end
                end
            end
            ESCREVENDO: begin
                if (livre) begin
                    if (fim_reg) begin
                        estado_next = FIM;
                    end else if (cab_reg) begin
                        envia    = 1'b1;
                        env_dado = idx_reg[4] ? CMD_LINHA2 : CMD_LINHA1;
                        cab_next = 1'b0;
                    end else begin
                        envia    = 1'b1;
                        env_rs   = 1'b1;
                        env_dado = caractere;
                        if (idx_reg == 5'd31) begin
                            fim_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + 5'd1;
                            if (idx_reg == 5'd15) cab_next = 1'b1;
                        end
                    end
                end
            end
            FIM: begin
                estado_next = habilitar ? OCIOSO : DESLIGANDO;
            end
            DESLIGANDO: begin
                if (livre) begin
                    if (fim_reg) begin
                        estado_next = DESLIGADO;
                    end else begin
                        envia    = 1'b1;
                        env_dado = CMD_DISP_OFF;
                        fim_next = 1'b1;
                    end
                end
            end
            default: begin
                if (livre) begin
                    if (fim_reg) begin
                        estado_next = OCIOSO;
                    end else if (habilitar) begin
                        envia    = 1'b1;
                        env_dado = CMD_LIGAR;
                        fim_next = 1'b1;
                    end
                end
            end
        endcase
        if (estado_next != estado_reg) begin
            idx_next = 5'd0;
            cab_next = 1'b1;
            fim_next = 1'b0;
        end
    end

    lcd_escritor_byte #(
        .T_EN_CYC    (T_EN_CYC),
        .T_CMD_CYC   (T_CMD_CYC),
        .T_CLEAR_CYC (T_CLEAR_CYC)
    ) u_escritor (
        .clk      (clk),
        .rst_n    (rst_n),
        .envia    (envia),
        .rs       (env_rs),
        .dado     (env_dado),
        .livre    (livre),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    assign pronto    = (estado_reg == OCIOSO);
    assign ocupado   = (estado_reg == LIMPANDO) || (estado_reg == ESCREVENDO);
    assign concluido = (estado_reg == FIM);
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_controlador_lcd.sv
// Self-checking bench for controlador_lcd: byte-level bus monitor against an expected-byte queue.
// Honours LCD_CURSOR_PISCANTE_EN for the expected display-on command.
module tb_controlador_lcd;

    localparam int TP  = 20;
    localparam int TE  = 2;
    localparam int TC  = 4;
    localparam int TCL = 10;

`ifdef LCD_CURSOR_PISCANTE_EN
    localparam logic [7:0] LIGA = 8'h0F;
`else
    localparam logic [7:0] LIGA = 8'h0C;
`endif

    logic         clk = 1'b0;
    logic         rst_n, habilitar, inicio, limpar;
    logic [127:0] linha1, linha2;
    logic         pronto, ocupado, concluido, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]   lcd_data;

    always #5 clk = ~clk;

    controlador_lcd #(
        .T_POWERUP_CYC (TP),
        .T_EN_CYC      (TE),
        .T_CMD_CYC     (TC),
        .T_CLEAR_CYC   (TCL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .habilitar (habilitar),
        .inicio    (inicio),
        .limpar    (limpar),
        .linha1    (linha1),
        .linha2    (linha2),
        .pronto    (pronto),
        .ocupado   (ocupado),
        .concluido (concluido),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data)
    );

    int tests = 0;
    int fails = 0;

    // Expected bus bytes as {rs, data}, in order
    logic [8:0] exp_q[$];
    logic [8:0] esperado;
    int xfers = 0, conc_count = 0, conc_exp = 0;
    int last_gap_clear = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_rs = 1'b0;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nome, act, req);
        end
    endtask

    task automatic chk_range(input string nome, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d..%0d", nome, act, lo, hi);
        end
    endtask

    function automatic int espera(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? TCL : TC;
    endfunction

    // ---------------- bus monitor ----------------
    logic       e_prev = 1'b0, rs_prev = 1'b0, conc_prev = 1'b0, have_prev = 1'b0;
    logic [7:0] data_prev = 8'h00, cur_data = 8'h00;
    logic       cur_rs = 1'b0;
    int         hi_cnt = 0, lo_cnt = 0, since_rst = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev = 1'b0; have_prev = 1'b0; conc_prev = 1'b0;
            hi_cnt = 0; lo_cnt = 0; since_rst = 0;
        end else begin
            since_rst++;
            chk("rw_tied_low", lcd_rw, 0);
            chk("pronto_and_ocupado", pronto & ocupado, 0);
            if (concluido) begin
                conc_count++;
                chk("concluido_single", conc_prev, 0);
                chk("ocupado_at_concluido", ocupado, 0);
            end
            conc_prev = concluido;
            if (lcd_e && !e_prev) begin
                chk("setup_rs", lcd_rs, rs_prev);
                chk("setup_data", lcd_data, data_prev);
                if (have_prev) begin
                    chk_range("gap", lo_cnt, espera(cur_rs, cur_data) + 1, 1000);
                    if (!cur_rs && cur_data == 8'h01) last_gap_clear = lo_cnt;
                end else begin
                    chk_range("powerup_wait", since_rst, TP + 1, 1000);
                end
                xfers++;
                $display("[TB] xfer %0d rs=%0d data=0x%02h", xfers, lcd_rs, lcd_data);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL xfer_unexpected: got rs=%0d data=0x%02h, required no transfer",
                             lcd_rs, lcd_data);
                end else begin
                    esperado = exp_q.pop_front();
                    chk("xfer_byte", {lcd_rs, lcd_data}, esperado);
                end
                cur_rs = lcd_rs; cur_data = lcd_data;
                last_rs = lcd_rs; last_data = lcd_data;
                hi_cnt = 1;
            end else if (lcd_e) begin
                hi_cnt++;
                chk("hold_rs_e", lcd_rs, cur_rs);
                chk("hold_data_e", lcd_data, cur_data);
            end else if (e_prev) begin
                chk("e_width", hi_cnt, TE);
                have_prev = 1'b1;
                lo_cnt = 1;
                chk("hold_data_wait", {lcd_rs, lcd_data}, {cur_rs, cur_data});
            end else if (have_prev) begin
                lo_cnt++;
                if (lo_cnt <= espera(cur_rs, cur_data))
                    chk("hold_data_wait", {lcd_rs, lcd_data}, {cur_rs, cur_data});
            end
            e_prev = lcd_e; rs_prev = lcd_rs; data_prev = lcd_data;
        end
    end

    // ---------------- model helpers ----------------
    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, LIGA});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[127 - 8*i -: 8]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[127 - 8*i -: 8]});
    endtask

    function automatic logic [127:0] rnd_linha();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = 8'($urandom_range(32, 126));
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pronto(input int max);
        int n = 0;
        while (!pronto && n < max) begin @(negedge clk); n++; end
        chk("pronto_reached", pronto, 1);
    endtask

    task automatic wait_conc(input int max);
        int n = 0;
        while (conc_count < conc_exp && n < max) begin @(negedge clk); n++; end
        chk("concluido_count", conc_count, conc_exp);
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin @(negedge clk); n++; end
        chk("queue_drained", exp_q.size(), 0);
        tick(TCL + 4);
    endtask

    task automatic pulso(input logic ini, input logic lim);
        inicio = ini; limpar = lim;
        @(negedge clk);
        inicio = 1'b0; limpar = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, n, op;
        rst_n = 1'b0; habilitar = 1'b1; inicio = 1'b0; limpar = 1'b0;
        linha1 = '0; linha2 = '0;
        tick(3);
        chk("rst_pronto", pronto, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_concluido", concluido, 0);
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_data", lcd_data, 0);

        // Power-up and init
        push_init();
        rst_n = 1'b1;
        for (int i = 0; i < TP; i++) begin @(negedge clk); chk("e_low_powerup", lcd_e, 0); end
        wait_pronto(400);
        chk("init_xfers", xfers, 4);
        chk("init_queue", exp_q.size(), 0);
        chk_range("gap_after_clear", last_gap_clear, TCL + 1, 1000);
        chk("init_last_byte", {last_rs, last_data}, {1'b0, 8'h06});

        // Fixed frame
        linha1 = "CALC 3+4        ";
        linha2 = "RES 7           ";
        base = xfers;
        push_frame(linha1, linha2); conc_exp++;
        pulso(1'b1, 1'b0);
        chk("ocupado_after_accept", ocupado, 1);
        chk("pronto_after_accept", pronto, 0);
        n = 0;
        while (xfers < base + 2 && n < 200) begin @(negedge clk); n++; end
        chk("frame_first_char", {last_rs, last_data}, {1'b1, 8'h43});
        wait_conc(1000);
        chk("frame_xfers", xfers - base, 34);
        chk("frame_last_char", {last_rs, last_data}, {1'b1, 8'h20});
        wait_pronto(5);

        // inicio and limpar together: only the clear runs
        base = xfers;
        linha1 = rnd_linha();
        exp_q.push_back({1'b0, 8'h01}); conc_exp++;
        inicio = 1'b1; limpar = 1'b1;
        @(negedge clk);
        inicio = 1'b0; limpar = 1'b0;
        n = 1;
        while (!concluido && n < 100) begin @(negedge clk); n++; end
        chk_range("clear_latency", n, 13, 16);
        chk("clear_xfers", xfers - base, 1);
        wait_pronto(5);

        // Requests mid-frame are ignored; later line changes are not displayed
        base = xfers;
        linha1 = rnd_linha(); linha2 = rnd_linha();
        push_frame(linha1, linha2); conc_exp++;
        pulso(1'b1, 1'b0);
        tick(40);
        linha1 = rnd_linha();
        pulso(1'b1, 1'b0);
        tick(30);
        pulso(1'b0, 1'b1);
        wait_conc(1000);
        tick(TC + 4);
        chk("midframe_xfers", xfers - base, 34);
        chk("midframe_queue", exp_q.size(), 0);
        wait_pronto(5);

        // habilitar falls mid-frame: frame completes, then display off
        base = xfers;
        linha1 = rnd_linha(); linha2 = rnd_linha();
        push_frame(linha1, linha2); exp_q.push_back({1'b0, 8'h08}); conc_exp++;
        pulso(1'b1, 1'b0);
        tick(30);
        habilitar = 1'b0;
        wait_conc(1000);
        wait_drain(200);
        chk("off_pronto", pronto, 0);
        chk("off_ocupado", ocupado, 0);
        pulso(1'b1, 1'b0);
        tick(20);
        chk("off_ignored", xfers - base, 35);
        chk("off_pronto_still", pronto, 0);
        exp_q.push_back({1'b0, LIGA});
        habilitar = 1'b1;
        wait_pronto(100);
        chk("on_xfers", xfers - base, 36);
        chk("on_last_byte", {last_rs, last_data}, {1'b0, LIGA});

        // Reset while E is high
        linha1 = rnd_linha(); linha2 = rnd_linha();
        push_frame(linha1, linha2);
        pulso(1'b1, 1'b0);
        n = 0;
        while (!lcd_e && n < 50) begin @(negedge clk); n++; end
        chk("e_seen_before_reset", lcd_e, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_drops_e", lcd_e, 0);
        chk("reset_pronto", pronto, 0);
        chk("reset_ocupado", ocupado, 0);
        exp_q.delete();
        tick(3);
        base = xfers;
        push_init();
        rst_n = 1'b1;
        wait_pronto(400);
        chk("reinit_xfers", xfers - base, 4);
        chk("reinit_queue", exp_q.size(), 0);

        // Randomised requests
        for (int k = 0; k < 8; k++) begin
            tick($urandom_range(0, 4));
            base = xfers;
            linha1 = rnd_linha(); linha2 = rnd_linha();
            op = $urandom_range(0, 2);
            if (op == 0) begin
                push_frame(linha1, linha2);
                pulso(1'b1, 1'b0);
            end else begin
                exp_q.push_back({1'b0, 8'h01});
                pulso(op == 2, 1'b1);
            end
            conc_exp++;
            if (op == 0) linha2 = rnd_linha();
            wait_conc(1000);
            chk("rand_xfers", xfers - base, (op == 0) ? 34 : 1);
            wait_pronto(20);
        end

        chk("final_queue", exp_q.size(), 0);
        chk("final_concluido", conc_count, conc_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controlador_lcd.md
Name: controlador_lcd

Overview:
- Sequences the 16x2 HD44780-compatible character LCD on behalf of the CPU FSM.
- Runs the power-up wait and init command sequence, then accepts frame-write and clear requests.
- For each request it emits the byte-level RS/E/DATA timing.
- The CPU drives it from its display-preparation states and waits on `pronto`; the LCD pins are driven only by this block.

Parameters:
- T_POWERUP_CYC, 1_000_000: cycles waited after reset before the first command (20 ms at 50 MHz).
- T_EN_CYC, 50: cycles `lcd_e` is held high per byte (1 us).
- T_CMD_CYC, 2_500: post-byte wait for ordinary commands and data (50 us).
- T_CLEAR_CYC, 100_000: post-byte wait after 0x01 clear or 0x02 home (2 ms).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- habilitar  in  1  level; 1 = display on, 0 = display off
- inicio  in  1  single-cycle pulse; write linha1/linha2 to the display
- limpar  in  1  single-cycle pulse; clear the display
- linha1  in  128  16 ASCII chars; [127:120] = leftmost column
- linha2  in  128  second row, same packing
- pronto  out  1  high when idle and initialised; requests accepted only while high
- ocupado  out  1  high from request acceptance until completion (not during init)
- concluido  out  1  single-cycle pulse when a frame or clear completes
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_e  out  1  enable strobe
- lcd_data  out  8  data bus

Behaviour:
- Reset (async, rst_n low): state ESPERA_LIGAR. All outputs 0; timers 0. Reset mid-transfer drops `lcd_e` immediately.
- Byte transfer is one unit, 1 + T_EN_CYC + wait cycles:
  - cycle 0: setup, RS/DATA valid, E low;
  - next T_EN_CYC cycles: E high;
  - then E low for T_CMD_CYC, or T_CLEAR_CYC if the byte is command 0x01/0x02.
  - RS/DATA are held stable for the whole transfer.
  - A transfer is never aborted except by reset.
- States:
  - ESPERA_LIGAR: count T_POWERUP_CYC, then INIT.
  - INIT: send 0x38, 0x0C, 0x01, 0x06 in order, then OCIOSO (or DESLIGADO if `habilitar` is 0).
  - OCIOSO: `pronto` = 1.
    - `limpar` -> LIMPANDO.
    - else `inicio` -> capture linha1/linha2 into internal registers, then ESCREVENDO.
    - else `habilitar` = 0 -> DESLIGANDO.
  - LIMPANDO: send 0x01, then FIM.
  - ESCREVENDO: send 0x80, linha1 chars 0..15 (RS = 1), 0xC0, linha2 chars 0..15, then FIM. Total 34 transfers.
  - FIM: `concluido` pulse for 1 cycle, then OCIOSO.
  - DESLIGANDO: send 0x08, then DESLIGADO.
  - DESLIGADO: `pronto` = 0. When `habilitar` = 1, send 0x0C, then OCIOSO.
- `limpar` and `inicio` asserted in the same cycle: limpar wins; inicio is dropped.
- Requests while `pronto` = 0 are ignored, not queued.
- `habilitar` falling during ESCREVENDO/LIMPANDO: the current operation completes (`concluido` still pulses), then DESLIGANDO.
- Line data is sampled only at acceptance; later changes to linha1/linha2 do not affect the frame in progress.
- Character index counter is 5 bits, 0..31, and never wraps past 31.
- `ocupado` rises the cycle after acceptance and falls with the `concluido` pulse.

Optional Feature:
- Macro LCD_CURSOR_PISCANTE_EN.
- Defined: the display-on command is 0x0F (cursor on, blinking) in INIT and on leaving DESLIGADO.
- Undefined: the command is 0x0C (cursor off).
- No other difference; timing identical.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - command constants CMD_FUNC_8BIT_2L = 0x38, CMD_DISP_ON = 0x0C, CMD_DISP_ON_CUR = 0x0F, CMD_DISP_OFF = 0x08, CMD_CLEAR = 0x01, CMD_ENTRY = 0x06, CMD_LINHA1 = 0x80, CMD_LINHA2 = 0xC0.
- Sub-module lcd_escritor_byte owns the RS/E/DATA timing and delay counter.
  - Handshake: `envia` pulse with `rs`/`byte`, and `livre` high when idle.
  - It is instantiated once in controlador_lcd.

Test Plan:
- All tests use T_POWERUP_CYC = 20, T_EN_CYC = 2, T_CMD_CYC = 4, T_CLEAR_CYC = 10.
- Reset release, `habilitar` = 1 -> after 20 cycles, bytes 0x38, 0x0C, 0x01, 0x06 with RS = 0. E high exactly 2 cycles each; 10-cycle gap after 0x01. Then `pronto` = 1.
- `inicio`, linha1 = "CALC 3+4        ", linha2 = "RES 7           " -> bus sequence 0x80, 'C'..' ', 0xC0, 'R'..' '. RS = 1 only on chars. `concluido` pulses once after the 34th transfer.
- `inicio` and `limpar` in the same cycle -> only 0x01 sent. `concluido` pulses 10 + 1 + 2 cycles later; no char writes.
- `inicio` pulsed again mid-frame -> ignored. Exactly 34 transfers; linha1 changed mid-frame is not displayed.
- `habilitar` -> 0 mid-frame -> frame completes, then 0x08, `pronto` = 0. `habilitar` -> 1 -> 0x0C (0x0F with LCD_CURSOR_PISCANTE_EN), `pronto` = 1.
- rst_n low while `lcd_e` = 1 -> `lcd_e` 0 immediately. After release, the full init repeats.
